rv32im_csr_access_unit: RTL and testbench
=========================================

// Module: rv32im_csr_access_unit
// PURPOSE
//  Initiator side of the CSR read/write port. Takes one decoded Zicsr instruction from execute
//  (CSRRW/S/C and immediate forms) and sequences read-modify-write on the CSR regfile's
//  csr_addr/read_en/write_en/val ports. Returns old CSR value for rd writeback, with valid/ready
//  handshakes on both sides. Sits between execute stage and rv32im_csr_regfile.
// PARAMETERS
//  XLEN      `API_XLEN (32)  data width
//  ADDR_W    `CSR_WIDTH (12) CSR address width
//  RO_CHECK  1               1: write to addr[11:10]==2'b11 (read-only space) flags illegal
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       asynchronous, active-high reset
//  req_valid_i    in   1       instruction valid
//  req_ready_o    out  1       unit idle, accepts request
//  req_funct3_i   in   3       001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  req_addr_i     in   ADDR_W  CSR address
//  req_rs1_val_i  in   XLEN    rs1 register value
//  req_rs1_idx_i  in   5       rs1 index / zimm field
//  req_rd_idx_i   in   5       destination index
//  csr_addr_o     out  ADDR_W  to regfile csr_addr_i
//  csr_read_en_o  out  1       to regfile csr_read_en_i
//  csr_write_en_o out  1       to regfile csr_write_en_i
//  csr_wdata_o    out  XLEN    to regfile val_csr_i
//  csr_rdata_i    in   XLEN    from regfile val_csr_o (combinational read)
//  rsp_valid_o    out  1       result valid
//  rsp_ready_i    in   1       writeback accepts result
//  rsp_rd_data_o  out  XLEN    old CSR value (0 if not read)
//  rsp_rd_idx_o   out  5       captured rd
//  rsp_rd_we_o    out  1       1 iff read performed and rd!=0
//  rsp_illegal_o  out  1       bad funct3 (000/100) or RO write
// BEHAVIOUR
//  - Reset: FSM=IDLE; req_ready_o=1; all csr_* strobes 0; csr_addr_o/csr_wdata_o=0; rsp_*=0.
//  - req_ready_o=1 only in IDLE; accept on req_valid_i&req_ready_o, register all req fields.
//  - src = funct3[2] ? {27'b0,rs1_idx} : rs1_val. do_read = !(RW/RWI && rd==0).
//    do_write = RW/RWI || rs1_idx!=0. illegal = funct3 in {000,100} || (RO_CHECK && do_write &&
//    addr[11:10]==2'b11).
//  - FSM IDLE->(illegal)RESP | (do_read)READ | WRITE.
//    READ: csr_read_en_o=1 one cycle, csr_rdata_i latched at edge; ->WRITE if do_write else RESP.
//    WRITE: csr_write_en_o=1 exactly one cycle, csr_wdata_o = RW:src, RS:old|src, RC:old&~src
//      (old=0 if not read; only RW skips read, so RS/RC always use true old); ->RESP.
//    RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; on handshake ->IDLE.
//  - Latency accept->rsp_valid: 3 cycles read+write, 2 cycles single access, 1 cycle illegal.
//  - csr_addr_o held at captured address READ..WRITE; strobes never both high in one cycle.
//  - Illegal: no strobe asserted, rsp_rd_we_o=0, rsp_illegal_o=1.
//  - No back-to-back overlap: new request only after RESP handshake (one IDLE cycle min).
//  - rst_i mid-operation: immediate return to IDLE, strobes drop same instant, in-flight op lost
//    (a half-done RMW never issues its write).
//  - rsp_ready_i held low: stays in RESP indefinitely, no further CSR traffic.
// STRUCTURE
//  - FSM state encodings, funct3 codes, RO address field in DEFINITIONS.v beside CSR_* addresses.
//  - Optional sub-module rv32im_csr_alu (combinational RW/RS/RC merge); rest is one FSM.
// TESTING
//  - CSRRW rd=5 addr MSCRATCH rs1=0xDEADBEEF, CSR old 0x11 -> read, write 0xDEADBEEF, rd_data 0x11.
//  - CSRRS rs1_idx=0 addr MSTATUS -> read only, csr_write_en_o never high, rd_we=1.
//  - CSRRCI zimm=0x8 old 0x0000_1888 -> wdata 0x0000_1880; CSRRWI rd=0 -> no read, rd_we=0.
//  - CSRRW addr 0xF11 (MVENDORID) -> rsp_illegal_o=1 one cycle after accept, no strobes.
//  - rsp_ready_i low 10 cycles with req_valid_i high -> req_ready_o=0, rsp outputs stable.
//  - rst_i asserted in READ -> strobes 0 immediately, IDLE, req_ready_o=1 after release.

Source files
------------

// File: rtl/rv32im_csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: FSM states, Zicsr funct3 codes,
// the read-only address field and a few CSR addresses used around the core.
package rv32im_csr_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Merge operation is carried in funct3[1:0]; funct3[2] only selects the source.
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // addr[11:10] == 2'b11 marks the read-only CSR space.
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;

  // funct3 000 and 100 are not Zicsr encodings.
  function automatic logic f3_is_bad(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rv32im_csr_access_unit_alu.sv
// Combinational read-modify-write merge for CSRRW/RS/RC (and immediate forms).
module rv32im_csr_access_unit_alu
  import rv32im_csr_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] res_o
);

  // Select the new CSR value from the old value and the source operand.
  always_comb begin
    res_o = src_i;
    case (op_i)
      OP_RW:   res_o = src_i;
      OP_RS:   res_o = old_i | src_i;
      OP_RC:   res_o = old_i & ~src_i;
      default: res_o = src_i;
    endcase
  end

endmodule

// File: rtl/rv32im_csr_access_unit.sv
// Initiator side of the CSR port: accepts one Zicsr instruction, sequences the
// read and/or write strobes toward the CSR regfile and returns the old value.
module rv32im_csr_access_unit
  import rv32im_csr_access_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 12,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_rs1_val_i,
  input  logic [4:0]        req_rs1_idx_i,
  input  logic [4:0]        req_rd_idx_i,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic              csr_read_en_o,
  output logic              csr_write_en_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rd_data_o,
  output logic [4:0]        rsp_rd_idx_o,
  output logic              rsp_rd_we_o,
  output logic              rsp_illegal_o
);

  csr_state_e        state_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   src_q, old_q;
  logic              do_write_q, rd_we_q;
  logic              req_ready_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              rsp_valid_q, rsp_rd_we_q, rsp_illegal_q;
  logic [XLEN-1:0]   rsp_rd_data_q;
  logic [4:0]        rsp_rd_idx_q;

  logic [XLEN-1:0]   src_d;
  logic              is_rw_d, do_read_d, do_write_d, illegal_d;
  logic [1:0]        alu_op;
  logic [XLEN-1:0]   alu_old, alu_src, alu_res;

  // Decode the incoming request; only meaningful while idle.
  always_comb begin
    src_d      = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_val_i;
    is_rw_d    = req_funct3_i[1:0] == OP_RW;
    do_read_d  = !(is_rw_d && req_rd_idx_i == 5'd0);
    do_write_d = is_rw_d || req_rs1_idx_i != 5'd0;
    illegal_d  = f3_is_bad(req_funct3_i) ||
                 (RO_CHECK && do_write_d && req_addr_i[ADDR_W-1 -: 2] == CSR_RO_FIELD);
  end

  // One merge unit: fed from the request when a write is issued straight from
  // IDLE (RW without read, old is zero), else from the captured request and live read data.
  always_comb begin
    alu_op  = op_q;
    alu_src = src_q;
    alu_old = '0;
    if (state_q == ST_IDLE) begin
      alu_op  = req_funct3_i[1:0];
      alu_src = src_d;
    end else if (state_q == ST_READ) begin
      alu_old = csr_rdata_i;
    end
  end

  rv32im_csr_access_unit_alu #(.XLEN(XLEN)) u_alu (
    .op_i  (alu_op),
    .old_i (alu_old),
    .src_i (alu_src),
    .res_o (alu_res)
  );

  // Sequencer with registered outputs; reset drops the strobes immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      src_q         <= '0;
      old_q         <= '0;
      do_write_q    <= 1'b0;
      rd_we_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_rd_idx_q  <= '0;
      rsp_rd_we_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q  <= 1'b0;
            op_q         <= req_funct3_i[1:0];
            src_q        <= src_d;
            old_q        <= '0;
            do_write_q   <= do_write_d;
            rd_we_q      <= do_read_d && req_rd_idx_i != 5'd0;
            addr_q       <= req_addr_i;
            rsp_rd_idx_q <= req_rd_idx_i;
            if (illegal_d) begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_rd_data_q <= '0;
              rsp_rd_we_q   <= 1'b0;
              rsp_illegal_q <= 1'b1;
            end else if (do_read_d) begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= ST_WRITE;
              wr_en_q <= 1'b1;
              wdata_q <= alu_res;
            end
          end
        end
        ST_READ: begin
          rd_en_q <= 1'b0;
          old_q   <= csr_rdata_i;
          if (do_write_q) begin
            state_q <= ST_WRITE;
            wr_en_q <= 1'b1;
            wdata_q <= alu_res;
          end else begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_rd_data_q <= csr_rdata_i;
            rsp_rd_we_q   <= rd_we_q;
            rsp_illegal_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          wr_en_q       <= 1'b0;
          state_q       <= ST_RESP;
          rsp_valid_q   <= 1'b1;
          rsp_rd_data_q <= old_q;
          rsp_rd_we_q   <= rd_we_q;
          rsp_illegal_q <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign csr_addr_o     = addr_q;
  assign csr_read_en_o  = rd_en_q;
  assign csr_write_en_o = wr_en_q;
  assign csr_wdata_o    = wdata_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rd_data_o  = rsp_rd_data_q;
  assign rsp_rd_idx_o   = rsp_rd_idx_q;
  assign rsp_rd_we_o    = rsp_rd_we_q;
  assign rsp_illegal_o  = rsp_illegal_q;

endmodule

// File: tb/tb_rv32im_csr_access_unit.sv
// Scoreboard bench for the CSR access unit: the driver queues expected
// responses and CSR writes, a monitor pops and checks them as the DUT emits them.
module tb_rv32im_csr_access_unit;
  import rv32im_csr_access_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = '0;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_rs1_val_i = '0;
  logic [4:0]  req_rs1_idx_i = '0;
  logic [4:0]  req_rd_idx_i = '0;
  logic [11:0] csr_addr_o;
  logic        csr_read_en_o;
  logic        csr_write_en_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rd_data_o;
  logic [4:0]  rsp_rd_idx_o;
  logic        rsp_rd_we_o;
  logic        rsp_illegal_o;

  always #5 clk_i = ~clk_i;

  rv32im_csr_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
    .req_rs1_val_i(req_rs1_val_i), .req_rs1_idx_i(req_rs1_idx_i),
    .req_rd_idx_i(req_rd_idx_i),
    .csr_addr_o(csr_addr_o), .csr_read_en_o(csr_read_en_o),
    .csr_write_en_o(csr_write_en_o), .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rd_data_o(rsp_rd_data_o), .rsp_rd_idx_o(rsp_rd_idx_o),
    .rsp_rd_we_o(rsp_rd_we_o), .rsp_illegal_o(rsp_illegal_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        we;
    logic        ill;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [43:0] wr_q[$];
  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: strobe accounting, write checks and response checks at negedge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (csr_read_en_o) rd_cnt++;
      if (csr_write_en_o) begin
        wr_cnt++;
        if (csr_read_en_o) chk("strobes_exclusive", 32'd1, 32'd0);
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          logic [43:0] w;
          w = wr_q.pop_front();
          chk("wr_addr", {20'd0, csr_addr_o}, {20'd0, w[43:32]});
          chk("wr_data", csr_wdata_o, w[31:0]);
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rd_data", rsp_rd_data_o, e.data);
          chk("rsp_rd_idx", {27'd0, rsp_rd_idx_o}, {27'd0, e.idx});
          chk("rsp_rd_we", {31'd0, rsp_rd_we_o}, {31'd0, e.we});
          chk("rsp_illegal", {31'd0, rsp_illegal_o}, {31'd0, e.ill});
        end
      end
    end
  end

  task automatic run_req(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1v, input logic [4:0] rs1i,
                         input logic [4:0] rd, input logic [31:0] old,
                         input logic [31:0] exp_data, input logic exp_we,
                         input logic exp_ill, input int exp_rd, input int exp_wr,
                         input logic [31:0] exp_wdata, input int exp_lat,
                         input int stall);
    int n, lat, rd0, wr0;
    rsp_t e;
    e.data = exp_data; e.idx = rd; e.we = exp_we; e.ill = exp_ill;
    rsp_q.push_back(e);
    if (exp_wr != 0) wr_q.push_back({addr, exp_wdata});
    n = 0;
    while (!req_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    csr_rdata_i = old;
    req_funct3_i = f3; req_addr_i = addr; req_rs1_val_i = rs1v;
    req_rs1_idx_i = rs1i; req_rd_idx_i = rd;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
    chk("latency", lat, exp_lat);
    if (stall > 0) begin
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk_i); #1;
        chk("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("stall_rsp_data", rsp_rd_data_o, exp_data);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    chk("read_strobes", rd_cnt - rd0, exp_rd);
    chk("write_strobes", wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_strobes", {30'd0, csr_read_en_o, csr_write_en_o}, 32'd0);
    chk("rst_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("rst_wdata", csr_wdata_o, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    //       f3         addr           rs1v          rs1i  rd     old           data          we    ill   rd wr wdata         lat stall
    run_req(F3_CSRRW,  CSR_MSCRATCH,  32'hDEADBEEF, 5'd7, 5'd5, 32'h00000011, 32'h00000011, 1'b1, 1'b0, 1, 1, 32'hDEADBEEF, 3, 0);
    run_req(F3_CSRRS,  CSR_MSTATUS,   32'h12345678, 5'd0, 5'd3, 32'h00001800, 32'h00001800, 1'b1, 1'b0, 1, 0, 32'h0,        2, 0);
    run_req(F3_CSRRCI, CSR_MSCRATCH,  32'hFFFFFFFF, 5'd8, 5'd4, 32'h00001888, 32'h00001888, 1'b1, 1'b0, 1, 1, 32'h00001880, 3, 0);
    run_req(F3_CSRRWI, CSR_MSCRATCH,  32'hFFFFFFFF, 5'h15,5'd0, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0, 0, 1, 32'h00000015, 2, 0);
    run_req(F3_CSRRW,  CSR_MVENDORID, 32'h00000001, 5'd1, 5'd2, 32'h55555555, 32'h00000000, 1'b0, 1'b1, 0, 0, 32'h0,        1, 0);
    run_req(3'b000,    CSR_MSCRATCH,  32'h00000001, 5'd1, 5'd6, 32'h55555555, 32'h00000000, 1'b0, 1'b1, 0, 0, 32'h0,        1, 0);
    run_req(F3_CSRRS,  CSR_MSCRATCH,  32'h000000F0, 5'd2, 5'd0, 32'h00000F00, 32'h00000F00, 1'b0, 1'b0, 1, 1, 32'h00000FF0, 3, 0);
    run_req(F3_CSRRSI, CSR_MVENDORID, 32'hFFFFFFFF, 5'd0, 5'd10,32'h0000ABCD, 32'h0000ABCD, 1'b1, 1'b0, 1, 0, 32'h0,        2, 0);
    run_req(F3_CSRRC,  CSR_MSCRATCH,  32'hFFFF0000, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1, 1, 32'h00005678, 3, 0);
    run_req(F3_CSRRS,  CSR_MSTATUS,   32'h00000000, 5'd0, 5'd11,32'h0A0B0C0D, 32'h0A0B0C0D, 1'b1, 1'b0, 1, 0, 32'h0,        2, 10);

    // Reset while in READ: strobes drop at once and the write never issues.
    begin
      int wr0;
      wr0 = wr_cnt;
      req_funct3_i = F3_CSRRW; req_addr_i = CSR_MSCRATCH; req_rs1_val_i = 32'h0BADF00D;
      req_rs1_idx_i = 5'd3; req_rd_idx_i = 5'd7; csr_rdata_i = 32'h1;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("pre_rst_read_en", {31'd0, csr_read_en_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_strobes", {30'd0, csr_read_en_o, csr_write_en_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      chk("post_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
      chk("post_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("post_rst_no_write", wr_cnt - wr0, 32'd0);
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
